// File: rtl/xgmii_pkg.sv
// Shared XGMII receive definitions: control character codes, lane access
// helpers, the frame FSM state type and the decoded-word record.
package xgmii_pkg;

    localparam logic [7:0] XGMII_START     = 8'hFB;
    localparam logic [7:0] XGMII_TERM      = 8'hFD;
    localparam logic [7:0] XGMII_ERROR     = 8'hFE;
    localparam logic [7:0] XGMII_IDLE      = 8'h07;
    localparam int         PREAMBLE_OCTETS = 7;
    localparam int         LANES           = 8;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } frame_state_t;

    typedef struct packed {
        logic       start_vld;
        logic       start_hi;
        logic       term_vld;
        logic [2:0] term_lane;
        logic       err;
        logic [7:0] fmask;
        logic [3:0] cnt_before;
        logic [3:0] cnt_after;
        logic [3:0] cnt_all;
    } word_dec_t;

    function automatic logic lane_ctrl(input logic [71:0] w, input int unsigned lane);
        return w[9*lane + 8];
    endfunction

    function automatic logic [7:0] lane_data(input logic [71:0] w, input int unsigned lane);
        return w[9*lane +: 8];
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {13'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/xgmii_word_decode.sv
// Combinational decode of one 72-bit XGMII word into start/terminate
// positions, error and foreign-control flags, and data-octet counts.
module xgmii_word_decode
    import xgmii_pkg::*;
(
    input  logic [71:0] rx,
    output word_dec_t   dec
);

    logic       lane0_start_s;
    logic       lane4_start_s;
    logic [2:0] start_lane_s;

    // A valid Start only exists in lane 0 or lane 4; lane 0 wins if both.
    always_comb begin
        lane0_start_s = lane_ctrl(rx, 0) && (lane_data(rx, 0) == XGMII_START);
        lane4_start_s = lane_ctrl(rx, 4) && (lane_data(rx, 4) == XGMII_START);
        start_lane_s  = (!lane0_start_s && lane4_start_s) ? 3'd4 : 3'd0;
    end

    // Scan the lanes for the first Terminate, errors, foreign ctrl and data counts.
    always_comb begin
        logic hit_v;
        logic c_v;
        logic is_start_v;
        logic is_term_v;
        dec           = '0;
        hit_v         = 1'b0;
        c_v           = 1'b0;
        is_start_v    = 1'b0;
        is_term_v     = 1'b0;
        dec.start_vld = lane0_start_s || lane4_start_s;
        dec.start_hi  = !lane0_start_s && lane4_start_s;
        for (int i = 0; i < LANES; i++) begin
            hit_v         = lane_ctrl(rx, i) && (lane_data(rx, i) == XGMII_TERM) && !dec.term_vld;
            dec.term_lane = hit_v ? 3'(i) : dec.term_lane;
            dec.term_vld  = dec.term_vld | hit_v;
            dec.err       = dec.err | (lane_ctrl(rx, i) && (lane_data(rx, i) == XGMII_ERROR));
        end
        // Only the opening Start and the closing Terminate are legitimate ctrl lanes.
        for (int i = 0; i < LANES; i++) begin
            c_v            = lane_ctrl(rx, i);
            is_start_v     = dec.start_vld && (3'(i) == start_lane_s);
            is_term_v      = dec.term_vld && (3'(i) == dec.term_lane);
            dec.fmask[i]   = c_v && !is_start_v && !is_term_v;
            dec.cnt_all    = dec.cnt_all + {3'd0, !c_v};
            dec.cnt_before = dec.cnt_before + {3'd0, !c_v && (!dec.term_vld || (3'(i) < dec.term_lane))};
            dec.cnt_after  = dec.cnt_after + {3'd0, !c_v && dec.start_vld && (3'(i) > start_lane_s)};
        end
    end

endmodule

// File: rtl/xgmii_rx_stats.sv
// Passive XGMII receive statistics tap: frame delineation, good/bad
// classification and per-PPS-window frame and octet counters.
module xgmii_rx_stats
    import xgmii_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 32,
    parameter int OCT_W   = 48
) (
    input  logic             xgmii_clk,
    input  logic             xgmii_resetn,
    input  logic [71:0]      xgmii_rx,
    input  logic             pps_pulse,
    output logic [CNT_W-1:0] stat_good_frames,
    output logic [CNT_W-1:0] stat_bad_frames,
    output logic [OCT_W-1:0] stat_good_octets,
    output logic             stat_valid,
    output logic             in_frame
);

    logic [71:0]      rx_r;
    logic             pps_r;
    word_dec_t        dec_s;
    word_dec_t        dec_r;
    logic             pps_d_r;

    frame_state_t     state_r;
    frame_state_t     state_nxt_s;
    logic [15:0]      raw_r;
    logic [15:0]      raw_nxt_s;
    logic             fbad_r;
    logic             fbad_nxt_s;

    logic [CNT_W-1:0] acc_good_r;
    logic [CNT_W-1:0] acc_bad_r;
    logic [OCT_W-1:0] acc_oct_r;

    logic [2:0]       start_lane_s;
    logic [7:0]       after_mask_s;
    logic [7:0]       before_mask_s;
    logic             term_first_s;
    logic             start_first_s;
    logic [15:0]      after_cnt_s;
    logic             after_bad_s;
    logic             before_bad_s;

    logic             close_vld_s;
    logic [15:0]      close_raw_s;
    logic             close_bad_s;
    logic [1:0]       extra_bad_s;
    logic [15:0]      len_s;
    logic             close_good_s;
    logic [15:0]      good_len_s;
    logic [1:0]       bad_inc_s;
    logic [CNT_W:0]   good_sum_s;
    logic [CNT_W:0]   bad_sum_s;
    logic [OCT_W:0]   oct_sum_s;
    logic [CNT_W-1:0] good_nxt_s;
    logic [CNT_W-1:0] bad_nxt_s;
    logic [OCT_W-1:0] oct_nxt_s;

    xgmii_word_decode u_decode (
        .rx  (rx_r),
        .dec (dec_s)
    );

    // Stage 1: capture the bus and the PPS strobe together.
    always_ff @(posedge xgmii_clk or negedge xgmii_resetn) begin
        if (!xgmii_resetn) begin
            rx_r  <= '0;
            pps_r <= 1'b0;
        end else begin
            rx_r  <= xgmii_rx;
            pps_r <= pps_pulse;
        end
    end

    // Stage 2 front: register the word decode with its aligned PPS strobe.
    always_ff @(posedge xgmii_clk or negedge xgmii_resetn) begin
        if (!xgmii_resetn) begin
            dec_r   <= '0;
            pps_d_r <= 1'b0;
        end else begin
            dec_r   <= dec_s;
            pps_d_r <= pps_r;
        end
    end

    assign start_lane_s  = dec_r.start_hi ? 3'd4 : 3'd0;
    assign after_mask_s  = dec_r.start_hi ? 8'hE0 : 8'hFE;
    assign before_mask_s = (8'h01 << dec_r.term_lane) - 8'h01;
    assign term_first_s  = dec_r.term_vld && (!dec_r.start_vld || (dec_r.term_lane < start_lane_s));
    assign start_first_s = dec_r.start_vld && !term_first_s;
    assign after_cnt_s   = {12'd0, dec_r.cnt_after};
    assign after_bad_s   = |(dec_r.fmask & after_mask_s);
    assign before_bad_s  = |(dec_r.fmask & before_mask_s);

    // Frame FSM next state; a Start ahead of a Terminate in one word yields a sub-7-octet bad frame.
    always_comb begin
        state_nxt_s = state_r;
        raw_nxt_s   = raw_r;
        fbad_nxt_s  = fbad_r;
        close_vld_s = 1'b0;
        close_raw_s = 16'd0;
        close_bad_s = 1'b0;
        extra_bad_s = 2'd0;
        case (state_r)
            IDLE: begin
                if (start_first_s && dec_r.term_vld) begin
                    extra_bad_s = 2'd1;
                end else if (start_first_s) begin
                    state_nxt_s = IN_FRAME;
                    raw_nxt_s   = after_cnt_s;
                    fbad_nxt_s  = after_bad_s;
                end else begin
                    state_nxt_s = IDLE;
                    raw_nxt_s   = 16'd0;
                    fbad_nxt_s  = 1'b0;
                end
            end
            IN_FRAME: begin
                if (term_first_s) begin
                    close_vld_s = 1'b1;
                    close_raw_s = sat_add16(raw_r, dec_r.cnt_before);
                    close_bad_s = fbad_r | before_bad_s;
                    if (dec_r.start_vld) begin
                        raw_nxt_s  = after_cnt_s;
                        fbad_nxt_s = after_bad_s;
                    end else begin
                        state_nxt_s = IDLE;
                        raw_nxt_s   = 16'd0;
                        fbad_nxt_s  = 1'b0;
                    end
                end else if (start_first_s && dec_r.term_vld) begin
                    extra_bad_s = 2'd2;
                    state_nxt_s = IDLE;
                    raw_nxt_s   = 16'd0;
                    fbad_nxt_s  = 1'b0;
                end else if (start_first_s) begin
                    extra_bad_s = 2'd1;
                    raw_nxt_s   = after_cnt_s;
                    fbad_nxt_s  = after_bad_s;
                end else begin
                    raw_nxt_s  = sat_add16(raw_r, dec_r.cnt_all);
                    fbad_nxt_s = fbad_r | dec_r.err | (|dec_r.fmask);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                raw_nxt_s   = 16'd0;
                fbad_nxt_s  = 1'b0;
            end
        endcase
    end

    // Classify the closing frame and form saturating accumulator sums.
    always_comb begin
        len_s        = close_raw_s - 16'(PREAMBLE_OCTETS);
        close_good_s = close_vld_s && !close_bad_s
                       && (close_raw_s >= 16'(PREAMBLE_OCTETS))
                       && (len_s >= 16'(MIN_LEN)) && (len_s <= 16'(MAX_LEN));
        good_len_s   = close_good_s ? len_s : 16'd0;
        bad_inc_s    = extra_bad_s + {1'b0, close_vld_s && !close_good_s};
        good_sum_s   = {1'b0, acc_good_r} + {{CNT_W{1'b0}}, close_good_s};
        bad_sum_s    = {1'b0, acc_bad_r} + {{(CNT_W-1){1'b0}}, bad_inc_s};
        oct_sum_s    = {1'b0, acc_oct_r} + {{(OCT_W-15){1'b0}}, good_len_s};
        good_nxt_s   = good_sum_s[CNT_W] ? {CNT_W{1'b1}} : good_sum_s[CNT_W-1:0];
        bad_nxt_s    = bad_sum_s[CNT_W] ? {CNT_W{1'b1}} : bad_sum_s[CNT_W-1:0];
        oct_nxt_s    = oct_sum_s[OCT_W] ? {OCT_W{1'b1}} : oct_sum_s[OCT_W-1:0];
    end

    // Frame FSM and per-frame octet/bad state.
    always_ff @(posedge xgmii_clk or negedge xgmii_resetn) begin
        if (!xgmii_resetn) begin
            state_r <= IDLE;
            raw_r   <= 16'd0;
            fbad_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            raw_r   <= raw_nxt_s;
            fbad_r  <= fbad_nxt_s;
        end
    end

    // Window accumulators; on PPS the snapshot includes any frame closing this cycle.
    always_ff @(posedge xgmii_clk or negedge xgmii_resetn) begin
        if (!xgmii_resetn) begin
            acc_good_r       <= '0;
            acc_bad_r        <= '0;
            acc_oct_r        <= '0;
            stat_good_frames <= '0;
            stat_bad_frames  <= '0;
            stat_good_octets <= '0;
            stat_valid       <= 1'b0;
        end else if (pps_d_r) begin
            acc_good_r       <= '0;
            acc_bad_r        <= '0;
            acc_oct_r        <= '0;
            stat_good_frames <= good_nxt_s;
            stat_bad_frames  <= bad_nxt_s;
            stat_good_octets <= oct_nxt_s;
            stat_valid       <= 1'b1;
        end else begin
            acc_good_r <= good_nxt_s;
            acc_bad_r  <= bad_nxt_s;
            acc_oct_r  <= oct_nxt_s;
            stat_valid <= 1'b0;
        end
    end

    assign in_frame = (state_r == IN_FRAME);

endmodule
